axil_adder8_slave: RTL
======================

Name: axil_adder8_slave

Overview:
- AXI4-Lite slave (responder) register interface for the 8-bit adder IP.
- Sits behind the block-design interconnect and answers the AXI VIP master's AXI4LITE write/read bursts.
- Holds operand and control registers, runs a registered two-stage 8-bit add, and exposes the result and status.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select one of 4 registers.

Ports:
- ACLK  in  1  single clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  4  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1  / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2  always OKAY (00)
- S_AXI_BVALID  out  1  / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  4  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always OKAY (00)
- S_AXI_RVALID  out  1  / S_AXI_RREADY  in  1

Behaviour:
- Register map:
  - 0x0 OPA: RW, 32 bits stored; bits [7:0] are operand A.
  - 0x4 OPB: RW, 32 bits stored; bits [7:0] are operand B.
  - 0x8 CTRL: RW, 32 bits stored; bit0 START, bit1 CIN.
  - 0xC STAT: RO; bits [8:0] SUM, bit16 DONE, bit31 BUSY, others 0.
- Reset (ARESETN low, asynchronous):
  - All READY/VALID outputs 0; BRESP, RRESP and RDATA 0.
  - OPA, OPB, CTRL, SUM, DONE and BUSY all 0.
  - An in-flight transaction is dropped, not completed.
- Write channel FSM, states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP:
  - AWREADY=1 in W_IDLE and W_HAVE_D; WREADY=1 in W_IDLE and W_HAVE_A.
  - AW and W may arrive in the same cycle or in either order; each is latched on its handshake.
  - When both are held, the register is updated in that cycle. BVALID rises the next cycle (W_RESP).
  - BVALID holds until BREADY; then return to W_IDLE. One outstanding write maximum.
  - WSTRB applies per byte to OPA, OPB and CTRL.
  - Writes to STAT are discarded but still answered OKAY.
- Read channel FSM, states R_IDLE, R_RESP:
  - ARREADY=1 only in R_IDLE.
  - On the AR handshake, RDATA is registered from register state before any same-cycle write update, and RVALID=1 the next cycle.
  - RDATA and RVALID hold stable until RREADY.
- Adder:
  - A write with START=1 to CTRL (byte 0 enabled) sets BUSY the cycle after the register update.
  - Stage 1 captures OPA[7:0], OPB[7:0] and CIN. Stage 2 computes SUM = A+B+CIN as a 9-bit value with carry in bit 8.
  - SUM, DONE=1 and BUSY=0 are visible 2 cycles after the write update.
  - START self-clears 1 cycle after the write update, so CTRL readback shows START=0.
  - Reading STAT returns the current DONE, then clears DONE in the cycle after the AR handshake (read-to-clear).
  - A START write while BUSY is ignored (no restart), still answered OKAY.
  - A new START clears DONE in the cycle it is accepted.
  - If a DONE set and a STAT read-clear coincide, the set wins.
- Address bits [1:0] are ignored.

Optional Feature:
- Macro ADDER_IRQ_EN.
- When defined: add output port irq (1 bit) and CTRL bit2 IRQ_ENABLE.
  - irq = DONE & IRQ_ENABLE, registered, reset 0.
  - irq clears through the same DONE read-clear.
- When undefined: no irq port; CTRL bit2 is stored but has no effect.

Test Plan:
- Write 0x1, 0x2, 0x3 to 0x0, 0x4, 0x8, then read them back → 0x1, 0x2 and 0x2 (START self-cleared, CIN=1). BRESP and RRESP are 00.
- OPA=0xFF, OPB=0x01, CTRL=0x3 → after 2 cycles STAT=0x00010101. A second STAT read returns 0x00000101.
- AW asserted 3 cycles before W, and separately W before AW → exactly one BVALID per write; the register is updated once.
- Hold BREADY/RREADY low for 5 cycles → BVALID/RVALID and RDATA stay stable; no further AW/AR accepted.
- Write CTRL START then immediately write CTRL START again while BUSY → the first result is unchanged; the second is ignored.
- Pull ARESETN low mid-write (after AW, before W) → all outputs 0 asynchronously. The next full write after reset completes normally.

Source files
------------

// File: rtl/axil_adder8_slave.sv
`default_nettype none
// ============================================================================
// axil_adder8_slave : AXI4-Lite register front end for a two-stage 8-bit adder
// Optional irq output and CTRL.IRQ_ENABLE under `ADDER_IRQ_EN.
// Rev 1.0
// ============================================================================
module axil_adder8_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
`ifdef ADDER_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam logic [1:0] c_sel_opa  = 2'd0;
  localparam logic [1:0] c_sel_opb  = 2'd1;
  localparam logic [1:0] c_sel_ctrl = 2'd2;
  localparam logic [1:0] c_sel_stat = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic [0:0] {R_IDLE, R_RESP} r_state_t;

  w_state_t r_wstate;
  r_state_t r_rstate;

  logic [1:0]                        r_waddr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   r_wstrb;

  logic [C_S_AXI_DATA_WIDTH-1:0]     r_opa;
  logic [C_S_AXI_DATA_WIDTH-1:0]     r_opb;
  logic [C_S_AXI_DATA_WIDTH-1:0]     r_ctrl;
  logic [7:0]                        r_a;
  logic [7:0]                        r_b;
  logic                              r_cin;
  logic                              r_stg1;
  logic [8:0]                        r_sum;
  logic                              r_done;
  logic                              r_busy;

  logic                              w_aw_hs;
  logic                              w_w_hs;
  logic                              w_ar_hs;
  logic                              w_wr_en;
  logic [1:0]                        w_wr_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0]     w_wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   w_wr_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0]     w_ctrl_wr;
  logic                              w_start;
  logic                              w_rd_clr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     w_stat;
  logic [C_S_AXI_DATA_WIDTH-1:0]     w_rd_mux;
  logic                              w_unused;

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] f_merge(
    input logic [C_S_AXI_DATA_WIDTH-1:0]   old_d,
    input logic [C_S_AXI_DATA_WIDTH-1:0]   new_d,
    input logic [C_S_AXI_DATA_WIDTH/8-1:0] strb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] m;
    m = old_d;
    for (int i = 0; i < C_S_AXI_DATA_WIDTH/8; i++) begin
      if (strb[i]) m[i*8 +: 8] = new_d[i*8 +: 8];
    end
    return m;
  endfunction

  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Write commits on the cycle the second half (address or data) arrives.
  assign w_wr_en   = (w_aw_hs || (r_wstate == W_HAVE_A)) && (w_w_hs || (r_wstate == W_HAVE_D));
  assign w_wr_sel  = (r_wstate == W_HAVE_A) ? r_waddr : S_AXI_AWADDR[3:2];
  assign w_wr_data = (r_wstate == W_HAVE_D) ? r_wdata : S_AXI_WDATA;
  assign w_wr_strb = (r_wstate == W_HAVE_D) ? r_wstrb : S_AXI_WSTRB;

  // START is masked while busy, so a write never restarts a running add.
  always_comb begin
    w_ctrl_wr    = f_merge(r_ctrl, w_wr_data, w_wr_strb);
    w_ctrl_wr[0] = w_wr_strb[0] & w_wr_data[0] & ~r_busy;
  end

  assign w_start  = w_wr_en && (w_wr_sel == c_sel_ctrl) && w_ctrl_wr[0];
  assign w_rd_clr = w_ar_hs && (S_AXI_ARADDR[3:2] == c_sel_stat);

  assign w_stat = {r_busy, 14'd0, r_done, 7'd0, r_sum};

  always_comb begin
    w_rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      c_sel_opa:  w_rd_mux = r_opa;
      c_sel_opb:  w_rd_mux = r_opb;
      c_sel_ctrl: w_rd_mux = r_ctrl;
      default:    w_rd_mux = w_stat;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate      <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_en) begin
            r_wstate      <= W_RESP;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
          end else if (w_aw_hs) begin
            r_waddr       <= S_AXI_AWADDR[3:2];
            r_wstate      <= W_HAVE_A;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
          end else if (w_w_hs) begin
            r_wdata       <= S_AXI_WDATA;
            r_wstrb       <= S_AXI_WSTRB;
            r_wstate      <= W_HAVE_D;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
          end else begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        W_HAVE_A: begin
          if (w_wr_en) begin
            r_wstate     <= W_RESP;
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b1;
          end
        end
        W_HAVE_D: begin
          if (w_wr_en) begin
            r_wstate      <= W_RESP;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
          end
        end
        default: begin
          if (S_AXI_BREADY) begin
            r_wstate      <= W_IDLE;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate      <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else if (r_rstate == R_IDLE) begin
      if (w_ar_hs) begin
        r_rstate      <= R_RESP;
        S_AXI_ARREADY <= 1'b0;
        S_AXI_RVALID  <= 1'b1;
        S_AXI_RDATA   <= w_rd_mux;
      end else begin
        S_AXI_ARREADY <= 1'b1;
      end
    end else if (S_AXI_RREADY) begin
      r_rstate      <= R_IDLE;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_ctrl <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_stg1 <= 1'b0;
      r_sum  <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      if (r_ctrl[0]) r_ctrl[0] <= 1'b0;
      if (w_wr_en) begin
        case (w_wr_sel)
          c_sel_opa:  r_opa  <= f_merge(r_opa, w_wr_data, w_wr_strb);
          c_sel_opb:  r_opb  <= f_merge(r_opb, w_wr_data, w_wr_strb);
          c_sel_ctrl: r_ctrl <= w_ctrl_wr;
          default:    ;
        endcase
      end

      // Stage 1 samples operands the cycle START is seen in CTRL.
      r_stg1 <= r_ctrl[0];
      if (r_ctrl[0]) begin
        r_a   <= r_opa[7:0];
        r_b   <= r_opb[7:0];
        r_cin <= r_ctrl[1];
      end

      if (w_start) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end
      if (w_rd_clr) r_done <= 1'b0;
      // Completion is last so a coincident read-clear loses to the set.
      if (r_stg1) begin
        r_sum  <= {1'b0, r_a} + {1'b0, r_b} + {8'd0, r_cin};
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

`ifdef ADDER_IRQ_EN
  logic r_irq;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_irq <= 1'b0;
    else          r_irq <= r_done & r_ctrl[2];
  end

  assign irq = r_irq;
`endif

endmodule
`default_nettype wire
